tx_router: RTL

- Host-to-peripheral counterpart of the RX arbitration path.
- Accepts the 32-bit word stream read from the FT601 and parses a header word to get the destination peripheral and the payload length.
- Steers each payload word into that peripheral's TX FIFO and holds off the host when the target FIFO is full.
- Drops, and counts, packets addressed to disabled peripherals so the stream stays framed.

---
 rtl/tx_router_pkg.sv | 25 ++
 rtl/tx_router.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/tx_router_pkg.sv
// Shared definitions for the FT601 host-to-peripheral router and the RX arbiter.
//   - router FSM state encoding
//   - header word field positions
//   - peripheral count / destination field width shared across the path
package tx_router_pkg;

  localparam int DATA_W     = 32;
  localparam int NUM_PERIPH = 8;
  localparam int ADDR_W     = 3;
  localparam int LEN_W      = 8;
  localparam int CNT_W      = 16;

  // Header word layout: destination in the top bits, payload length in the low byte.
  localparam int DEST_MSB = 31;
  localparam int DEST_LSB = 29;
  localparam int LEN_MSB  = 7;
  localparam int LEN_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2
  } state_t;

endpackage

// File: rtl/tx_router.sv
// tx_router: parses the FT601 read word stream into packets (header + N payload
// words) and steers payload words into the addressed peripheral's TX FIFO.
// Packets addressed to disabled (or non-existent) peripherals are consumed and
// counted so the stream stays framed.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   in_data/valid    word stream from the FT601 read path
//   in_ready         router accepts in_data this cycle
//   periph_enable    per-peripheral enable, sampled at header acceptance
//   tx_fifo_full     per-peripheral TX FIFO full flags
//   tx_fifo_wr_en    one-hot write strobe (same cycle as the accepted word)
//   tx_fifo_wdata    write data shared by all FIFOs (in_data pass-through)
//   active_dest      registered destination of the packet in progress
//   busy             registered, high while in PAYLOAD or DROP
//   drop_count       saturating count of dropped packets
//   drop_count_clr   synchronous clear of drop_count (wins over an increment)
//
// Handshake: a word transfers in any cycle where in_valid && in_ready; in_valid
// may be held with stable data while in_ready is low and nothing is consumed.
module tx_router #(
  parameter int DATA_W     = tx_router_pkg::DATA_W,
  parameter int NUM_PERIPH = tx_router_pkg::NUM_PERIPH,
  parameter int ADDR_W     = tx_router_pkg::ADDR_W,
  parameter int LEN_W      = tx_router_pkg::LEN_W,
  parameter int CNT_W      = tx_router_pkg::CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM_PERIPH-1:0] periph_enable,
  input  logic [NUM_PERIPH-1:0] tx_fifo_full,
  output logic [NUM_PERIPH-1:0] tx_fifo_wr_en,
  output logic [DATA_W-1:0]     tx_fifo_wdata,
  output logic [ADDR_W-1:0]     active_dest,
  output logic                  busy,
  output logic [CNT_W-1:0]      drop_count,
  input  logic                  drop_count_clr
);

  import tx_router_pkg::*;

  localparam int DEST_SPACE = 1 << ADDR_W;

  state_t              state;
  state_t              state_next;
  logic [LEN_W-1:0]    rem;
  logic                hs;
  logic [ADDR_W-1:0]   hdr_dest;
  logic [LEN_W-1:0]    hdr_len;
  logic                drop_inc;

  // Enable/full widened to the full destination space; unpopulated
  // destinations read as disabled so their packets are dropped.
  logic [DEST_SPACE-1:0] en_ext;
  logic [DEST_SPACE-1:0] full_ext;
  logic [DEST_SPACE-1:0] wr_ext;

  assign hdr_dest = in_data[DEST_MSB:DEST_LSB];
  assign hdr_len  = in_data[LEN_MSB:LEN_LSB];
  assign hs       = in_valid && in_ready;

  always_comb begin
    en_ext   = '0;
    full_ext = '0;
    en_ext[NUM_PERIPH-1:0]   = periph_enable;
    full_ext[NUM_PERIPH-1:0] = tx_fifo_full;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        // Zero-length headers are no-ops and leave the FSM in IDLE.
        if (hs && hdr_len != '0)
          state_next = en_ext[hdr_dest] ? ST_PAYLOAD : ST_DROP;
      end
      ST_PAYLOAD, ST_DROP: begin
        if (hs && rem == LEN_W'(1)) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output logic: ready and write strobe are combinational so a full flag
  // stalls the host in the same cycle it rises and words land with 0 latency.
  always_comb begin
    in_ready = 1'b1;
    wr_ext   = '0;
    case (state)
      ST_PAYLOAD: begin
        in_ready            = ~full_ext[active_dest];
        wr_ext[active_dest] = in_valid & ~full_ext[active_dest];
      end
      default: begin
        in_ready = 1'b1;
        wr_ext   = '0;
      end
    endcase
  end

  assign tx_fifo_wr_en = wr_ext[NUM_PERIPH-1:0];
  assign tx_fifo_wdata = in_data;

  // Packet context: latched on header acceptance, rem counts down per word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem         <= '0;
      active_dest <= '0;
      busy        <= 1'b0;
    end else begin
      busy <= (state_next != ST_IDLE);
      if (hs) begin
        if (state == ST_IDLE) begin
          rem         <= hdr_len;
          active_dest <= hdr_dest;
        end else begin
          rem <= rem - LEN_W'(1);
        end
      end
    end
  end

  assign drop_inc = (state == ST_IDLE) && hs && (hdr_len != '0) && !en_ext[hdr_dest];

  always_ff @(posedge clk) begin
    if (rst || drop_count_clr)
      drop_count <= '0;
    else if (drop_inc && drop_count != '1)
      drop_count <= drop_count + CNT_W'(1);
  end

endmodule
